// File: rtl/viterbi_dec.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 code (g1=101, g2=111), 4-state ACS with
// register-exchange survivors. Define VITERBI_ERRCNT_EN to add the err_cnt channel-error counter.
module viterbi_dec #(
    parameter int TB_DEPTH = 15,
    parameter int METRIC_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        code,
    input  logic        code_valid,
    output logic        bit_out,
    output logic        bit_valid
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [METRIC_W-1:0] METRIC_MAX  = {METRIC_W{1'b1}};
    localparam logic [METRIC_W-1:0] METRIC_INIT = METRIC_W'(3);

    // Hamming distance between the received pair and the branch label of (state, u).
    function automatic logic [1:0] branch_bm(input logic [1:0] sym, input logic [1:0] st, input logic u);
        logic [1:0] exp_v;
        logic [1:0] diff_v;
        exp_v  = {u ^ st[0], u ^ st[1] ^ st[0]};
        diff_v = sym ^ exp_v;
        return {1'b0, diff_v[1]} + {1'b0, diff_v[0]};
    endfunction

    function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] m, input logic [1:0] bm);
        logic [METRIC_W:0] sum_v;
        sum_v = {1'b0, m} + {{(METRIC_W-1){1'b0}}, bm};
        if (sum_v[METRIC_W]) begin
            return METRIC_MAX;
        end else begin
            return sum_v[METRIC_W-1:0];
        end
    endfunction

    logic                phase_r;
    logic                sym1_r;
    logic [CNT_W-1:0]    sym_cnt_r;
    logic                acs_d_r;
    logic                bit_out_r;
    logic                bit_valid_r;
    logic [METRIC_W-1:0] metric_r   [4];
    logic [TB_DEPTH-1:0] surv_r     [4];

    logic                acs_s;
    logic [1:0]          sym_s;
    logic [1:0]          bm0_s      [4];
    logic [1:0]          bm1_s      [4];
    logic [METRIC_W-1:0] cand0_s    [4];
    logic [METRIC_W-1:0] cand1_s    [4];
    logic                sel_s      [4];
    logic [METRIC_W-1:0] new_metric_s [4];
    logic [METRIC_W-1:0] norm_metric_s [4];
    logic [TB_DEPTH-1:0] new_surv_s [4];
    logic [METRIC_W-1:0] min_s;
    logic [1:0]          best_s;

    // Add-compare-select for all four next states; ties favour the predecessor with s0=0.
    always_comb begin : acs_comb
        logic [1:0] ns_v;
        logic [1:0] pred0_v;
        logic [1:0] pred1_v;
        ns_v          = 2'b00;
        pred0_v       = 2'b00;
        pred1_v       = 2'b01;
        sym_s         = {sym1_r, code};
        acs_s         = code_valid & phase_r;
        min_s         = METRIC_MAX;
        bm0_s         = '{default: 2'b00};
        bm1_s         = '{default: 2'b00};
        cand0_s       = '{default: '0};
        cand1_s       = '{default: '0};
        sel_s         = '{default: 1'b0};
        new_metric_s  = '{default: '0};
        norm_metric_s = '{default: '0};
        new_surv_s    = '{default: '0};
        for (int i = 0; i < 4; i++) begin
            ns_v       = 2'(i);
            pred0_v    = {ns_v[0], 1'b0};
            pred1_v    = {ns_v[0], 1'b1};
            bm0_s[i]   = branch_bm(sym_s, pred0_v, ns_v[1]);
            bm1_s[i]   = branch_bm(sym_s, pred1_v, ns_v[1]);
            cand0_s[i] = sat_add(metric_r[pred0_v], bm0_s[i]);
            cand1_s[i] = sat_add(metric_r[pred1_v], bm1_s[i]);
            if (cand1_s[i] < cand0_s[i]) begin
                sel_s[i]        = 1'b1;
                new_metric_s[i] = cand1_s[i];
                new_surv_s[i]   = {surv_r[pred1_v][TB_DEPTH-2:0], ns_v[1]};
            end else begin
                sel_s[i]        = 1'b0;
                new_metric_s[i] = cand0_s[i];
                new_surv_s[i]   = {surv_r[pred0_v][TB_DEPTH-2:0], ns_v[1]};
            end
            if (new_metric_s[i] < min_s) begin
                min_s = new_metric_s[i];
            end else begin
                min_s = min_s;
            end
        end
        for (int i = 0; i < 4; i++) begin
            norm_metric_s[i] = new_metric_s[i] - min_s;
        end
    end

    // Best state is the lowest-index state whose normalised metric is zero.
    always_comb begin
        best_s = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (metric_r[i] == '0) begin
                best_s = 2'(i);
            end else begin
                best_s = best_s;
            end
        end
    end

    // Pair deserialiser, path metrics, survivors and symbol counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r     <= 1'b0;
            sym1_r      <= 1'b0;
            sym_cnt_r   <= '0;
            acs_d_r     <= 1'b0;
            metric_r[0] <= '0;
            metric_r[1] <= METRIC_INIT;
            metric_r[2] <= METRIC_INIT;
            metric_r[3] <= METRIC_INIT;
            surv_r      <= '{default: '0};
        end else begin
            acs_d_r <= acs_s;
            if (code_valid) begin
                phase_r <= ~phase_r;
                if (!phase_r) begin
                    sym1_r <= code;
                end
            end
            if (acs_s) begin
                metric_r <= norm_metric_s;
                surv_r   <= new_surv_s;
                if (sym_cnt_r < CNT_W'(TB_DEPTH)) begin
                    sym_cnt_r <= sym_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    // Decoded bit is taken from the oldest survivor position one cycle after each ACS.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
        end else begin
            bit_valid_r <= acs_d_r & (sym_cnt_r == CNT_W'(TB_DEPTH));
            if (acs_d_r) begin
                bit_out_r <= surv_r[best_s][TB_DEPTH-1];
            end
        end
    end

    assign bit_out   = bit_out_r;
    assign bit_valid = bit_valid_r;

`ifdef VITERBI_ERRCNT_EN
    logic [1:0]  win_bm_r [4];
    logic [15:0] err_cnt_r;
    logic [16:0] err_sum_s;

    assign err_sum_s = {1'b0, err_cnt_r} + {15'd0, win_bm_r[best_s]};

    // Accumulates the branch metric that won into the best state, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_bm_r  <= '{default: 2'b00};
            err_cnt_r <= 16'd0;
        end else begin
            if (acs_s) begin
                for (int i = 0; i < 4; i++) begin
                    win_bm_r[i] <= sel_s[i] ? bm1_s[i] : bm0_s[i];
                end
            end
            if (acs_d_r) begin
                err_cnt_r <= err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
            end
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_viterbi_dec.sv
// Directed bench for viterbi_dec: reference encoder + M-series source, every cycle checks
// bit_valid timing and each decoded bit against the delayed info stream.
module tb_viterbi_dec;

    localparam int TB_DEPTH = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic code = 1'b0;
    logic code_valid = 1'b0;
    logic bit_out;
    logic bit_valid;
`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    viterbi_dec #(.TB_DEPTH(TB_DEPTH), .METRIC_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .code       (code),
        .code_valid (code_valid),
        .bit_out    (bit_out),
`ifdef VITERBI_ERRCNT_EN
        .err_cnt    (err_cnt),
`endif
        .bit_valid  (bit_valid)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    logic p1 = 1'b0;
    logic p2 = 1'b0;
    logic phase_m = 1'b0;
    int   sym_cnt_m = 0;
    logic q[$];
    logic enc_s1 = 1'b0;
    logic enc_s0 = 1'b0;
    logic [6:0] lfsr = 7'h7F;
    int   valid_seen = 0;
    int   ones_seen = 0;
    int   one_pos = 0;
    int   flips = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs of the last edge, then drive inputs for the next edge.
    task automatic step(input logic v, input logic b, input logic r);
        logic e;
        @(negedge clk);
        chk("bit_valid", {31'd0, bit_valid}, {31'd0, p2});
        if (bit_valid === 1'b1) valid_seen++;
        if (p2 && q.size() > 0) begin
            e = q.pop_front();
            chk("bit_out", {31'd0, bit_out}, {31'd0, e});
            if (bit_out === 1'b1) begin
                ones_seen++;
                one_pos = valid_seen;
            end
        end
        p2 = p1;
        p1 = 1'b0;
        rst = r;
        code_valid = v;
        code = b;
        if (r) begin
            phase_m = 1'b0;
            sym_cnt_m = 0;
            p2 = 1'b0;
            q.delete();
        end else if (v) begin
            if (phase_m) begin
                if (sym_cnt_m < TB_DEPTH) sym_cnt_m++;
                p1 = (sym_cnt_m == TB_DEPTH);
            end
            phase_m = ~phase_m;
        end
    endtask

    task automatic idle_gap();
        int n;
        n = 0;
        while ($urandom_range(0, 1) == 1 && n < 4) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
    endtask

    task automatic send_sym(input logic u, input logic [1:0] flip, input bit gaps);
        logic c1;
        logic c2;
        c1 = u ^ enc_s0;
        c2 = u ^ enc_s1 ^ enc_s0;
        q.push_back(u);
        enc_s0 = enc_s1;
        enc_s1 = u;
        if (gaps) idle_gap();
        step(1'b1, c1 ^ flip[1], 1'b0);
        if (gaps) idle_gap();
        step(1'b1, c2 ^ flip[0], 1'b0);
    endtask

    task automatic prbs(output logic u);
        u = lfsr[6];
        lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    endtask

    // Reset is driven together with a valid code bit, which must be dropped.
    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1);
        enc_s1 = 1'b0;
        enc_s0 = 1'b0;
        lfsr = 7'h7F;
        valid_seen = 0;
        ones_seen = 0;
        one_pos = 0;
        flips = 0;
    endtask

    initial begin
        logic u;
        logic [1:0] fl;

        // Reset state and all-zero stream
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        chk("rst_bit_out", {31'd0, bit_out}, 32'd0);
        chk("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
`ifdef VITERBI_ERRCNT_EN
        chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
        for (int i = 0; i < 14; i++) send_sym(1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_no_early_valid", 32'(valid_seen), 32'd0);
        send_sym(1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_first_valid_sym15", 32'(valid_seen), 32'd1);
        for (int i = 0; i < 20; i++) send_sym(1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_zero_ones", 32'(ones_seen), 32'd0);

        // M-series, gapless, 515 symbols -> 501 decoded bits
        do_reset();
        for (int i = 0; i < 515; i++) begin
            prbs(u);
            send_sym(u, 2'b00, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_count", 32'(valid_seen), 32'd501);

        // Same stream with one flipped code bit every 10 symbols
        do_reset();
        for (int i = 0; i < 300; i++) begin
            prbs(u);
            fl = 2'b00;
            if (i % 10 == 5 && i < 260) begin
                fl = ((i / 10) % 2 == 0) ? 2'b10 : 2'b01;
                flips++;
            end
            send_sym(u, fl, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_count", 32'(valid_seen), 32'd286);
`ifdef VITERBI_ERRCNT_EN
        chk("t3_err_cnt", {16'd0, err_cnt}, 32'(flips));
`endif

        // Impulse: single 1 must appear on the first decoded bit only
        do_reset();
        send_sym(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 29; i++) send_sym(1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_ones", 32'(ones_seen), 32'd1);
        chk("t4_one_pos", 32'(one_pos), 32'd1);
        chk("t4_count", 32'(valid_seen), 32'd16);

        // Random gaps between code bits
        do_reset();
        for (int i = 0; i < 200; i++) begin
            prbs(u);
            send_sym(u, 2'b00, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t5_count", 32'(valid_seen), 32'd186);

        // Reset after the first bit of pair 40, then restart from a fresh encoder
        do_reset();
        for (int i = 0; i < 39; i++) begin
            prbs(u);
            send_sym(u, 2'b00, 1'b0);
        end
        prbs(u);
        step(1'b1, u ^ enc_s0, 1'b0);
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        chk("t6_valid_low", {31'd0, bit_valid}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            prbs(u);
            send_sym(u, 2'b00, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_count", 32'(valid_seen), 32'd26);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
